// File: rtl/mmio_bus_mux.sv
// rtl/mmio_bus_mux.sv - decoded, handshaked CPU-to-peripheral MMIO interconnect
// Optional WAIT-state timeout is compiled in when BUS_TIMEOUT_EN is defined.
module mmio_bus_mux #(
  parameter int NUM_SLAVES     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                addr,
  input  logic [31:0]                write_data,
  input  logic                       enable,
  input  logic                       is_write,
  input  logic [3:0]                 byte_sel,
  output logic [31:0]                data_out,
  output logic                       ready,
  output logic                       err,
  output logic                       busy,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic                       s_we,
  output logic [3:0]                 s_byte_sel,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready
);

  if (NUM_SLAVES < 2 || NUM_SLAVES > 65 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("mmio_bus_mux: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q;
  logic [NUM_SLAVES-1:0] s_sel_q;
  logic [31:0]           data_out_q;
  logic                  ready_q;
  logic                  err_q;
  logic                  busy_q;
  logic [31:0]           s_addr_q;
  logic [31:0]           s_wdata_q;
  logic                  s_we_q;
  logic [3:0]            s_byte_sel_q;

  logic [NUM_SLAVES-1:0] sel_d;
  logic [31:0]           rdata_d;
  logic                  hit_ready;
  logic                  tmo_hit;

  // Slave 0 owns the low 64 KiB; IO slots are 16-byte windows in the top 1 KiB.
  always_comb begin
    sel_d = '0;
    if (addr[31:16] == 16'h0000) begin
      sel_d[0] = 1'b1;
    end else if (addr[31:10] == 22'h3FFFFF) begin
      for (int k = 1; k < NUM_SLAVES; k++) begin
        if (addr[9:4] == 6'(k - 1)) sel_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_sel_q[k]) rdata_d = rdata_d | s_rdata[32*k +: 32];
    end
  end

  assign hit_ready = |(s_ready & s_sel_q);

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      tmo_cnt_q <= '0;
    end else if (!hit_ready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      s_sel_q      <= '0;
      data_out_q   <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_we_q       <= 1'b0;
      s_byte_sel_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            s_addr_q     <= addr;
            s_wdata_q    <= write_data;
            s_we_q       <= is_write;
            s_byte_sel_q <= byte_sel;
            busy_q       <= 1'b1;
            if (|sel_d) begin
              state_q <= ST_WAIT;
              s_sel_q <= sel_d;
            end else begin
              state_q    <= ST_RESP;
              ready_q    <= 1'b1;
              err_q      <= 1'b1;
              data_out_q <= '0;
            end
          end
        end
        ST_WAIT: begin
          // A slave answering on the timeout cycle still completes normally.
          if (hit_ready) begin
            state_q    <= ST_RESP;
            s_sel_q    <= '0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            data_out_q <= s_we_q ? 32'h0 : rdata_d;
          end else if (tmo_hit) begin
            state_q    <= ST_RESP;
            s_sel_q    <= '0;
            ready_q    <= 1'b1;
            err_q      <= 1'b1;
            data_out_q <= '0;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign ready      = ready_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign s_sel      = s_sel_q;
  assign s_addr     = s_addr_q;
  assign s_wdata    = s_wdata_q;
  assign s_we       = s_we_q;
  assign s_byte_sel = s_byte_sel_q;

endmodule

// File: tb/tb_mmio_bus_mux.sv
// tb/tb_mmio_bus_mux.sv - directed self-checking bench for mmio_bus_mux
// Timeout steps are included only when BUS_TIMEOUT_EN is defined.
module tb_mmio_bus_mux;
  localparam int NS = 10;

  logic              clk;
  logic              rst;
  logic [31:0]       addr;
  logic [31:0]       write_data;
  logic              enable;
  logic              is_write;
  logic [3:0]        byte_sel;
  logic [31:0]       data_out;
  logic              ready;
  logic              err;
  logic              busy;
  logic [NS-1:0]     s_sel;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic              s_we;
  logic [3:0]        s_byte_sel;
  logic [32*NS-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_bus_mux #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data), .enable(enable),
    .is_write(is_write), .byte_sel(byte_sel), .data_out(data_out), .ready(ready),
    .err(err), .busy(busy), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_we(s_we), .s_byte_sel(s_byte_sel), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] bs);
    addr       = a;
    is_write   = wr;
    write_data = wd;
    byte_sel   = bs;
    enable     = 1'b1;
    tick();
    enable     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; addr = '0; write_data = '0; enable = 1'b0; is_write = 1'b0;
    byte_sel = '0; s_ready = '0;
    for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = 32'hC0DE0000 + 32'(k);
    s_rdata[31:0] = 32'hDEADBEEF;

    tick(); tick();
    check("rst_ready", {63'h0, ready}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_s_sel", {54'h0, s_sel}, 64'h0);
    check("rst_data_out", {32'h0, data_out}, 64'h0);
    rst = 1'b1;
    tick();

    // Read slave 0 with s_ready tied high: ready in cycle 2.
    s_ready[0] = 1'b1;
    request(32'h0000_0040, 1'b0, 32'h0, 4'hF);
    check("rd0_c1_s_sel", {54'h0, s_sel}, 64'h001);
    check("rd0_c1_busy", {63'h0, busy}, 64'h1);
    check("rd0_c1_ready", {63'h0, ready}, 64'h0);
    check("rd0_c1_s_addr", {32'h0, s_addr}, 64'h40);
    tick();
    check("rd0_c2_ready", {63'h0, ready}, 64'h1);
    check("rd0_c2_err", {63'h0, err}, 64'h0);
    check("rd0_c2_data", {32'h0, data_out}, 64'hDEADBEEF);
    check("rd0_c2_s_sel", {54'h0, s_sel}, 64'h0);
    tick();
    check("rd0_c3_ready", {63'h0, ready}, 64'h0);
    check("rd0_c3_hold", {32'h0, data_out}, 64'hDEADBEEF);
    check("rd0_c3_busy", {63'h0, busy}, 64'h0);

    // Unmapped address: error completion in cycle 1, no slave selected.
    request(32'h0010_0000, 1'b0, 32'h0, 4'hF);
    check("unm_ready", {63'h0, ready}, 64'h1);
    check("unm_err", {63'h0, err}, 64'h1);
    check("unm_data", {32'h0, data_out}, 64'h0);
    check("unm_s_sel", {54'h0, s_sel}, 64'h0);
    tick();
    check("unm_c2_ready", {63'h0, ready}, 64'h0);
    check("unm_c2_err_hold", {63'h0, err}, 64'h1);

    // Slot 9 would be slave 10, beyond NUM_SLAVES.
    request(32'hFFFF_FC90, 1'b0, 32'h0, 4'hF);
    check("slot9_err", {63'h0, err}, 64'h1);
    check("slot9_ready", {63'h0, ready}, 64'h1);
    check("slot9_s_sel", {54'h0, s_sel}, 64'h0);
    tick();

    // Highest slot (slave 9), zero wait states.
    s_ready[9] = 1'b1;
    request(32'hFFFF_FC80, 1'b0, 32'h0, 4'hF);
    check("slot8_s_sel", {54'h0, s_sel}, 64'h200);
    tick();
    check("slot8_ready", {63'h0, ready}, 64'h1);
    check("slot8_err", {63'h0, err}, 64'h0);
    check("slot8_data", {32'h0, data_out}, 64'hC0DE0009);
    s_ready[9] = 1'b0;
    tick();

    // Write slot 3 (slave 4), ready after 5 wait cycles.
    request(32'hFFFF_FC30, 1'b1, 32'h1234_5678, 4'b0011);
    check("wr_c1_s_sel", {54'h0, s_sel}, 64'h010);
    check("wr_c1_s_wdata", {32'h0, s_wdata}, 64'h12345678);
    check("wr_c1_s_we", {63'h0, s_we}, 64'h1);
    check("wr_c1_s_bs", {60'h0, s_byte_sel}, 64'h3);
    check("wr_c1_s_addr", {32'h0, s_addr}, 64'hFFFFFC30);
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 6) s_ready[4] = 1'b1;
      check($sformatf("wr_c%0d_s_sel", c), {54'h0, s_sel}, 64'h010);
      check($sformatf("wr_c%0d_ready", c), {63'h0, ready}, 64'h0);
    end
    tick();
    s_ready[4] = 1'b0;
    check("wr_c7_ready", {63'h0, ready}, 64'h1);
    check("wr_c7_err", {63'h0, err}, 64'h0);
    check("wr_c7_data", {32'h0, data_out}, 64'h0);
    check("wr_c7_s_sel", {54'h0, s_sel}, 64'h0);
    tick();

    // Slave 1 waits; other slaves' s_ready and an enable pulse are ignored.
    request(32'hFFFF_FC00, 1'b0, 32'h0, 4'hF);
    check("ns_c1_s_sel", {54'h0, s_sel}, 64'h002);
    s_ready[2] = 1'b1;
    addr = 32'h0010_0000;
    enable = 1'b1;
    tick();
    check("ns_c2_ready", {63'h0, ready}, 64'h0);
    check("ns_c2_s_sel", {54'h0, s_sel}, 64'h002);
    enable = 1'b0;
    s_ready[2] = 1'b0;
    tick();
    check("ns_c3_ready", {63'h0, ready}, 64'h0);
    s_ready[1] = 1'b1;
    tick();
    s_ready[1] = 1'b0;
    check("ns_ready", {63'h0, ready}, 64'h1);
    check("ns_err", {63'h0, err}, 64'h0);
    check("ns_data", {32'h0, data_out}, 64'hC0DE0001);
    tick();
    check("ns_after_ready", {63'h0, ready}, 64'h0);
    check("ns_after_busy", {63'h0, busy}, 64'h0);

    // Reset asserted in the 3rd WAIT cycle drops the transaction.
    request(32'hFFFF_FC10, 1'b1, 32'hCAFE_F00D, 4'hC);
    tick();
    tick();
    check("rw_c3_s_sel", {54'h0, s_sel}, 64'h004);
    #2 rst = 1'b0;
    #1;
    check("rw_s_sel", {54'h0, s_sel}, 64'h0);
    check("rw_busy", {63'h0, busy}, 64'h0);
    check("rw_data", {32'h0, data_out}, 64'h0);
    check("rw_s_addr", {32'h0, s_addr}, 64'h0);
    check("rw_s_wdata", {32'h0, s_wdata}, 64'h0);
    check("rw_s_we_bs", {59'h0, s_we, s_byte_sel}, 64'h0);
    tick();
    tick();
    check("rw_no_ready", {62'h0, ready, err}, 64'h0);
    rst = 1'b1;
    tick();
    request(32'h0000_0044, 1'b0, 32'h0, 4'hF);
    tick();
    check("post_rst_ready", {63'h0, ready}, 64'h1);
    check("post_rst_data", {32'h0, data_out}, 64'hDEADBEEF);
    tick();

`ifdef BUS_TIMEOUT_EN
    // Slave 2 never answers: error completion after 8 WAIT cycles.
    request(32'hFFFF_FC10, 1'b0, 32'h0, 4'hF);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        addr = 32'h0000_0000;
        enable = 1'b1;
      end
      if (c == 4) enable = 1'b0;
      check($sformatf("to_c%0d_busy", c), {63'h0, busy}, 64'h1);
      check($sformatf("to_c%0d_ready", c), {63'h0, ready}, 64'h0);
      check($sformatf("to_c%0d_s_sel", c), {54'h0, s_sel}, 64'h004);
      tick();
    end
    check("to_ready", {63'h0, ready}, 64'h1);
    check("to_err", {63'h0, err}, 64'h1);
    check("to_data", {32'h0, data_out}, 64'h0);
    check("to_s_sel", {54'h0, s_sel}, 64'h0);
    tick();
    check("to_after_ready", {63'h0, ready}, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
